// File: rtl/icache_axi_responder_if.sv
// AR/R read channel plus backing-store preload port for the icache refill responder.
// The slave modport is the responder side; master is the requester/preloader side.
interface icache_axi_responder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned MEM_WORDS  = 1024
);
   localparam int unsigned MemAw = $clog2(MEM_WORDS);

   logic                  ar_valid;
   logic                  ar_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [ID_WIDTH-1:0]   ar_id;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;

   logic                  r_valid;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_data;
   logic [ID_WIDTH-1:0]   r_id;
   logic [1:0]            r_resp;
   logic                  r_last;

   logic                  mem_we;
   logic [MemAw-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport slave (
      input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      input  r_ready,
      input  mem_we, mem_waddr, mem_wdata,
      output ar_ready,
      output r_valid, r_data, r_id, r_resp, r_last
   );

   modport master (
      output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      output r_ready,
      output mem_we, mem_waddr, mem_wdata,
      input  ar_ready,
      input  r_valid, r_data, r_id, r_resp, r_last
   );
endinterface

// File: rtl/icache_axi_responder.sv
// AXI read-slave end of the icache refill path: one outstanding burst, fixed start latency,
// INCR/WRAP bursts served from a preloadable word memory with SLVERR/DECERR reporting.
module icache_axi_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned LATENCY    = 2
) (
   input logic                  clk,
   input logic                  rst,
   icache_axi_responder_if.slave bus
);
   localparam int unsigned BeatBytes = DATA_WIDTH / 8;
   localparam int unsigned SizeLog2  = $clog2(BeatBytes);
   localparam int unsigned MemAw     = $clog2(MEM_WORDS);
   // WAIT lasts LATENCY cycles, so the counter starts one below and exits on zero.
   localparam logic [3:0]  LatInit   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   localparam logic [1:0] BurstFixed = 2'd0;
   localparam logic [1:0] BurstWrap  = 2'd2;
   localparam logic [1:0] BurstRsvd  = 2'd3;
   localparam logic [1:0] RespOkay   = 2'd0;
   localparam logic [1:0] RespSlverr = 2'd2;
   localparam logic [1:0] RespDecerr = 2'd3;

   typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] wmask_q, wmask_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            beat_q, beat_d;
   logic                  slverr_q, slverr_d;
   logic                  wrap_q, wrap_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (bus.mem_we) begin
         mem_q[bus.mem_waddr] <= bus.mem_wdata;
      end
   end

   logic                  wrap_len_ok;
   logic                  wrap_addr_ok;
   logic                  ar_slverr;
   logic [ADDR_WIDTH-1:0] ar_wmask;

   always_comb begin
      wrap_len_ok  = (bus.ar_len == 8'd1) || (bus.ar_len == 8'd3) ||
                     (bus.ar_len == 8'd7) || (bus.ar_len == 8'd15);
      wrap_addr_ok = (bus.ar_addr & ADDR_WIDTH'(BeatBytes - 1)) == '0;
      ar_slverr    = (bus.ar_size != 3'(SizeLog2)) ||
                     (bus.ar_burst == BurstFixed) || (bus.ar_burst == BurstRsvd) ||
                     ((bus.ar_burst == BurstWrap) && !(wrap_len_ok && wrap_addr_ok));
      // Byte mask of the wrap block: (len+1) beats of BeatBytes each.
      ar_wmask     = ((ADDR_WIDTH'(bus.ar_len) + ADDR_WIDTH'(1)) << SizeLog2) -
                     ADDR_WIDTH'(1);
   end

   logic [ADDR_WIDTH-1:0] addr_incr;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [MemAw-1:0]      word_idx;
   logic                  beat_decerr;
   logic                  r_valid;
   logic                  r_last;

   assign addr_incr   = addr_q + ADDR_WIDTH'(BeatBytes);
   assign addr_next   = wrap_q ? ((addr_q & ~wmask_q) | (addr_incr & wmask_q)) : addr_incr;
   assign word_addr   = addr_q >> SizeLog2;
   assign word_idx    = addr_q[SizeLog2 +: MemAw];
   assign beat_decerr = word_addr >= ADDR_WIDTH'(MEM_WORDS);
   assign r_valid     = (state_q == StBurst) && !rst;
   assign r_last      = r_valid && (beat_q == len_q);

   always_comb begin
      bus.ar_ready = (state_q == StIdle) && !rst;
      bus.r_valid  = r_valid;
      bus.r_last   = r_last;
      bus.r_id     = r_valid ? id_q : '0;
      bus.r_resp   = RespOkay;
      bus.r_data   = '0;
      if (r_valid) begin
         if (slverr_q) begin
            bus.r_resp = RespSlverr;
         end else if (beat_decerr) begin
            bus.r_resp = RespDecerr;
         end else begin
            bus.r_data = mem_q[word_idx];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wmask_d  = wmask_q;
      id_d     = id_q;
      len_d    = len_q;
      beat_d   = beat_q;
      slverr_d = slverr_q;
      wrap_d   = wrap_q;
      unique case (state_q)
         StIdle: begin
            if (bus.ar_valid && bus.ar_ready) begin
               addr_d   = bus.ar_addr;
               wmask_d  = ar_wmask;
               id_d     = bus.ar_id;
               len_d    = bus.ar_len;
               beat_d   = 8'd0;
               slverr_d = ar_slverr;
               wrap_d   = bus.ar_burst == BurstWrap;
               cnt_d    = LatInit;
               state_d  = (LATENCY == 0) ? StBurst : StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StBurst;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StBurst: begin
            if (bus.r_ready) begin
               if (r_last) begin
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = addr_next;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         wmask_q  <= '0;
         id_q     <= '0;
         len_q    <= 8'd0;
         beat_q   <= 8'd0;
         slverr_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wmask_q  <= wmask_d;
         id_q     <= id_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         slverr_q <= slverr_d;
         wrap_q   <= wrap_d;
      end
   end
endmodule

// File: tb/tb_icache_axi_responder.sv
// Bench for icache_axi_responder: a transaction-level model checked every cycle, plus
// literal expectations for the refill scenarios.
module tb_icache_axi_responder;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 32;
   localparam int unsigned IW  = 4;
   localparam int unsigned MW  = 1024;
   localparam int unsigned LAT = 2;
   localparam int unsigned BB  = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_axi_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                             .MEM_WORDS(MW)) bus ();

   icache_axi_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS(MW), .LATENCY(LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [1:0]    resp;
      logic          last;
      logic [IW-1:0] id;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] mdl_mem [MW];
   bit            busy = 0;
   int            wait_left = 0;
   int            cyc = 0;
   int            ar_cyc = 0;
   int            first_valid_cyc = -1;

   logic [DW-1:0] log_data[$];
   logic [1:0]    log_resp[$];
   logic          log_last[$];
   logic [IW-1:0] log_id[$];

   function automatic bit mdl_slverr(input longint addr, input int len, input int size,
                                     input int burst);
      int l = len + 1;
      if (size != $clog2(BB)) return 1;
      if (burst == 0 || burst == 3) return 1;
      if (burst == 2 && !(l == 2 || l == 4 || l == 8 || l == 16)) return 1;
      if (burst == 2 && (addr % BB) != 0) return 1;
      return 0;
   endfunction

   task automatic mdl_accept(input longint addr, input int id, input int len, input int size,
                             input int burst);
      bit     se   = mdl_slverr(addr, len, size, burst);
      longint blk  = longint'(len + 1) * BB;
      longint base = addr - (addr % blk);
      for (int i = 0; i <= len; i++) begin
         beat_t  b;
         longint a;
         if (burst == 2) a = base + ((addr - base + longint'(i) * BB) % blk);
         else            a = addr + longint'(i) * BB;
         b.addr = a[AW-1:0];
         b.resp = se ? 2'd2 : ((longint'(b.addr) / BB) >= MW ? 2'd3 : 2'd0);
         b.last = (i == len);
         b.id   = IW'(id);
         exp_q.push_back(b);
      end
   endtask

   // Compare against the model, then advance the model for the coming clock edge.
   always @(negedge clk) begin
      bit            ev;
      logic [DW-1:0] edata;
      cyc++;
      ev = !rst && busy && wait_left == 0;
      chk("ar_ready", bus.ar_ready, !rst && !busy);
      chk("r_valid", bus.r_valid, ev);
      if (rst) begin
         chk("rst_r_data", bus.r_data, 0);
         chk("rst_r_id", bus.r_id, 0);
         chk("rst_r_resp", bus.r_resp, 0);
         chk("rst_r_last", bus.r_last, 0);
      end
      if (ev && exp_q.size() > 0) begin
         edata = (exp_q[0].resp == 2'd0) ?
                 mdl_mem[int'((longint'(exp_q[0].addr) / BB) % MW)] : '0;
         chk("r_data", bus.r_data, edata);
         chk("r_resp", bus.r_resp, exp_q[0].resp);
         chk("r_last", bus.r_last, exp_q[0].last);
         chk("r_id", bus.r_id, exp_q[0].id);
      end
      if (!rst && bus.r_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!rst && bus.r_valid && bus.r_ready) begin
         log_data.push_back(bus.r_data);
         log_resp.push_back(bus.r_resp);
         log_last.push_back(bus.r_last);
         log_id.push_back(bus.r_id);
      end
      if (bus.mem_we) mdl_mem[bus.mem_waddr] = bus.mem_wdata;
      if (rst) begin
         busy = 0;
         exp_q.delete();
      end else if (!busy && bus.ar_valid) begin
         mdl_accept(longint'(bus.ar_addr), int'(bus.ar_id), int'(bus.ar_len),
                    int'(bus.ar_size), int'(bus.ar_burst));
         busy      = 1;
         wait_left = LAT;
         ar_cyc    = cyc;
      end else if (busy && wait_left > 0) begin
         wait_left--;
      end else if (busy && bus.r_ready) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) busy = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_resp.delete();
      log_last.delete();
      log_id.delete();
      first_valid_cyc = -1;
   endtask

   task automatic issue_ar(input logic [AW-1:0] addr, input int id, input int len,
                           input int size, input int burst);
      int g = 0;
      clear_log();
      bus.ar_addr  = addr;
      bus.ar_id    = IW'(id);
      bus.ar_len   = 8'(len);
      bus.ar_size  = 3'(size);
      bus.ar_burst = 2'(burst);
      bus.ar_valid = 1'b1;
      while (!bus.ar_ready && g < 50) begin
         step(1);
         g++;
      end
      if (g >= 50) chk("ar_timeout", 1, 0);
      step(1);
      bus.ar_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 300) begin
         step(1);
         g++;
      end
      chk("txn_done", busy, 0);
   endtask

   task automatic wait_r_valid();
      int g = 0;
      while (!bus.r_valid && g < 50) begin
         step(1);
         g++;
      end
      chk("r_valid_seen", bus.r_valid, 1);
   endtask

   bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      int g;
      rst           = 1'b1;
      bus.ar_valid  = 1'b0;
      bus.ar_addr   = '0;
      bus.ar_id     = '0;
      bus.ar_len    = '0;
      bus.ar_size   = '0;
      bus.ar_burst  = '0;
      bus.r_ready   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      step(3);
      rst = 1'b0;
      #1;
      chk("ar_ready_after_rst", bus.ar_ready, 1);

      for (int i = 0; i < MW; i++) begin
         bus.mem_we    = 1'b1;
         bus.mem_waddr = 10'(i);
         bus.mem_wdata = 32'h1000 + DW'(i);
         step(1);
      end
      bus.mem_we = 1'b0;

      // INCR refill, latency and data pinned by hand.
      bus.r_ready = 1'b1;
      issue_ar(32'h40, 5, 3, 2, 1);
      wait_idle();
      chk("incr_latency", first_valid_cyc - ar_cyc, 3);
      chk("incr_beats", log_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("incr_data", log_data[i], 32'h1010 + DW'(i));
         chk("incr_last", log_last[i], i == 3);
      end
      chk("incr_id", log_id[0], 5);
      chk("incr_resp", log_resp[3], 0);

      // WRAP, critical word first.
      issue_ar(32'h48, 6, 3, 2, 2);
      wait_idle();
      chk("wrap_d0", log_data[0], 32'h1012);
      chk("wrap_d1", log_data[1], 32'h1013);
      chk("wrap_d2", log_data[2], 32'h1010);
      chk("wrap_d3", log_data[3], 32'h1011);

      // Backpressure.
      bus.r_ready = 1'b0;
      issue_ar(32'h80, 3, 3, 2, 1);
      wait_r_valid();
      for (int i = 0; i < 7; i++) begin
         bus.r_ready = pat[i];
         step(1);
      end
      bus.r_ready = 1'b0;
      wait_idle();
      chk("bp_beats", log_data.size(), 4);
      chk("bp_d3", log_data[3], 32'h1023);

      // SLVERR cases.
      bus.r_ready = 1'b1;
      issue_ar(32'h40, 1, 0, 3, 1);
      wait_idle();
      chk("size_beats", log_data.size(), 1);
      chk("size_resp", log_resp[0], 2);
      chk("size_data", log_data[0], 0);
      chk("size_last", log_last[0], 1);
      issue_ar(32'h40, 2, 2, 2, 2);
      wait_idle();
      chk("wraplen_beats", log_data.size(), 3);
      chk("wraplen_resp", log_resp[1], 2);
      chk("wraplen_last1", log_last[1], 0);
      chk("wraplen_last2", log_last[2], 1);
      issue_ar(32'h0, 4, 1, 2, 0);
      wait_idle();
      chk("fixed_resp", log_resp[0], 2);

      // DECERR past the end of memory.
      issue_ar(32'hFF8, 12, 3, 2, 1);
      wait_idle();
      chk("dec_d0", log_data[0], 32'h13FE);
      chk("dec_d1", log_data[1], 32'h13FF);
      chk("dec_r1", log_resp[1], 0);
      chk("dec_r2", log_resp[2], 3);
      chk("dec_d3", log_data[3], 0);
      chk("dec_r3", log_resp[3], 3);

      // Write to the word being read in the same cycle returns old data.
      bus.r_ready = 1'b0;
      issue_ar(32'h100, 7, 1, 2, 1);
      wait_r_valid();
      bus.mem_we    = 1'b1;
      bus.mem_waddr = 10'd64;
      bus.mem_wdata = 32'hDEAD0000;
      bus.r_ready   = 1'b1;
      step(1);
      bus.mem_we = 1'b0;
      wait_idle();
      chk("rw_old", log_data[0], 32'h1040);
      issue_ar(32'h100, 7, 0, 2, 1);
      wait_idle();
      chk("rw_new", log_data[0], 32'hDEAD0000);

      // Reset mid-burst, then a fresh WRAP request.
      issue_ar(32'h200, 9, 7, 2, 1);
      g = 0;
      while (log_data.size() < 2 && g < 50) begin
         step(1);
         g++;
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", bus.r_valid, 0);
      step(1);
      rst = 1'b0;
      step(2);
      chk("rst_mid_beats", log_data.size(), 2);
      issue_ar(32'h3C, 10, 7, 2, 2);
      wait_idle();
      chk("post_rst_beats", log_data.size(), 8);
      chk("post_rst_d0", log_data[0], 32'h100F);
      chk("post_rst_d1", log_data[1], 32'h1008);
      chk("post_rst_d7", log_data[7], 32'h100E);
      chk("post_rst_id", log_id[7], 10);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
